peripheral_msi_slave_port_arb_ahb3: RTL and testbench

Parametrised, next-generation slave-port arbiter of the MSI AHB3-Lite interconnect. It sits in front of one AHB slave and multiplexes MASTERS master ports onto it. Arbitration is by programmable-width priority, with round-robin inside each level. New over the previous generation: per-master HREADYOUT/HRESP stalling of losing masters, HMASTLOCK and burst hold, SEQ→NONSEQ fix-up on switch, and a tracked data-phase owner.

---
 rtl/peripheral_msi_ahb3_pkg.sv | 64 ++++++
 rtl/peripheral_msi_arb_rr_ahb3.sv | 32 +++
 rtl/peripheral_msi_slave_port_arb_ahb3.sv | 209 ++++++++++++++++++++
 tb/tb_peripheral_msi_slave_port_arb_ahb3.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_msi_ahb3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_ahb3_pkg
//  Brief    : Shared AHB3-Lite encodings and arbitration helper functions for
//             the MSI interconnect slave-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package peripheral_msi_ahb3_pkg;

  typedef logic [1:0] htrans_t;
  typedef logic [2:0] hburst_t;
  typedef logic [2:0] hsize_t;

  // HTRANS encodings
  localparam htrans_t c_HTRANS_IDLE   = 2'b00;
  localparam htrans_t c_HTRANS_BUSY   = 2'b01;
  localparam htrans_t c_HTRANS_NONSEQ = 2'b10;
  localparam htrans_t c_HTRANS_SEQ    = 2'b11;

  // HBURST encodings
  localparam hburst_t c_HBURST_SINGLE = 3'b000;
  localparam hburst_t c_HBURST_INCR   = 3'b001;
  localparam hburst_t c_HBURST_WRAP4  = 3'b010;
  localparam hburst_t c_HBURST_INCR4  = 3'b011;
  localparam hburst_t c_HBURST_WRAP8  = 3'b100;
  localparam hburst_t c_HBURST_INCR8  = 3'b101;
  localparam hburst_t c_HBURST_WRAP16 = 3'b110;
  localparam hburst_t c_HBURST_INCR16 = 3'b111;

  // HSIZE encodings
  localparam hsize_t c_HSIZE_BYTE  = 3'b000;
  localparam hsize_t c_HSIZE_HWORD = 3'b001;
  localparam hsize_t c_HSIZE_WORD  = 3'b010;
  localparam hsize_t c_HSIZE_DWORD = 3'b011;

  // Index of the highest set bit of a one-hot vector (0 when empty).
  function automatic int onehot2int(input logic [31:0] oh);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i[4:0]]) res = i;
    end
    return res;
  endfunction

  // First candidate after 'last', wrapping modulo n (n <= 32).
  // Returns -1 when there is no candidate. Iterating from the far end down
  // lets the nearest candidate overwrite the result last.
  function automatic int rr_next(input logic [31:0] cand, input int last, input int n);
    int res;
    int idx;
    res = -1;
    for (int i = 32; i >= 1; i--) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (cand[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_msi_arb_rr_ahb3.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_arb_rr_ahb3
//  Brief    : Round-robin selector for one priority level: picks the first
//             candidate after the level's last-granted index, wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_arb_rr_ahb3
  import peripheral_msi_ahb3_pkg::*;
#(
  parameter int MASTERS = 5,
  parameter int IDXW    = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] cand,
  input  logic [IDXW-1:0]    last_idx,
  output logic [IDXW-1:0]    next_idx,
  output logic               next_valid
);

  logic [31:0] w_cand32;
  int          w_res;

  // Search the candidate set starting just after the last winner
  always_comb begin
    w_cand32   = 32'(cand);
    w_res      = rr_next(w_cand32, int'(last_idx), MASTERS);
    next_valid = (w_res >= 0);
    next_idx   = next_valid ? IDXW'(w_res) : last_idx;
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_msi_slave_port_arb_ahb3.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_slave_port_arb_ahb3
//  Brief    : AHB3-Lite slave-port arbiter. Multiplexes MASTERS master ports
//             onto one slave with priority + per-level round-robin, lock and
//             burst hold, SEQ->NONSEQ fix-up and data-phase owner tracking.
//  Options  : define MSI_ARB_STARVE_EN to enable starvation aging.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_slave_port_arb_ahb3
  import peripheral_msi_ahb3_pkg::*;
#(
  parameter int PLEN         = 64,
  parameter int XLEN         = 64,
  parameter int MASTERS      = 5,
  parameter int PRIO_BITS    = 3,
  parameter int BURST_HOLD   = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,

  input  logic [MASTERS-1:0][PRIO_BITS-1:0]   mstpriority,
  input  logic [MASTERS-1:0]                  mstHSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]        mstHADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]        mstHWDATA,
  input  logic [MASTERS-1:0]                  mstHWRITE,
  input  logic [MASTERS-1:0][2:0]             mstHSIZE,
  input  logic [MASTERS-1:0][2:0]             mstHBURST,
  input  logic [MASTERS-1:0][3:0]             mstHPROT,
  input  logic [MASTERS-1:0][1:0]             mstHTRANS,
  input  logic [MASTERS-1:0]                  mstHMASTLOCK,
  input  logic [MASTERS-1:0]                  mstHREADY,
  output logic [XLEN-1:0]                     mstHRDATA,
  output logic [MASTERS-1:0]                  mstHREADYOUT,
  output logic [MASTERS-1:0]                  mstHRESP,

  output logic                                slv_HSEL,
  output logic [PLEN-1:0]                     slv_HADDR,
  output logic [XLEN-1:0]                     slv_HWDATA,
  output logic                                slv_HWRITE,
  output logic [2:0]                          slv_HSIZE,
  output logic [2:0]                          slv_HBURST,
  output logic [3:0]                          slv_HPROT,
  output logic [1:0]                          slv_HTRANS,
  output logic                                slv_HMASTLOCK,
  output logic                                slv_HREADYOUT,
  input  logic [XLEN-1:0]                     slv_HRDATA,
  input  logic                                slv_HREADY,
  input  logic                                slv_HRESP,

  input  logic [MASTERS-1:0]                  can_switch,
  output logic [MASTERS-1:0]                  granted_master,
  output logic                                arb_locked
);

  localparam int IDXW = $clog2(MASTERS);
  localparam int NLVL = 2 ** PRIO_BITS;
  localparam logic [IDXW-1:0]    c_LAST_RST = IDXW'(MASTERS - 1);
  localparam logic [MASTERS-1:0] c_ONE      = MASTERS'(1);

  // Elaboration-time parameter sanity checks
  if ((MASTERS < 2) || (MASTERS > 32)) begin : g_bad_masters
    $error("MASTERS must be in 2..32");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [MASTERS-1:0]                w_req;
  logic [MASTERS-1:0][PRIO_BITS-1:0] w_eff;
  logic [PRIO_BITS-1:0]              w_level;
  logic [MASTERS-1:0]                w_cand;
  logic [IDXW-1:0]                   w_rr_next;
  logic                              w_rr_valid;
  logic                              w_legal;
  logic                              w_arb_point;
  logic                              w_switch;

  logic [IDXW-1:0]                   r_gidx;
  logic [MASTERS-1:0]                r_granted;
  logic [NLVL-1:0][IDXW-1:0]         r_last;
  logic                              r_first_beat;
  logic [IDXW-1:0]                   r_downer;
  logic                              r_dvalid;

  // A master requests whenever it is selected with NONSEQ or SEQ
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_req[m] = mstHSEL[m] & mstHTRANS[m][1];
    end
  end

`ifdef MSI_ARB_STARVE_EN
  localparam int                 c_CNTW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNTW-1:0]  c_LIMIT = c_CNTW'(STARVE_LIMIT);

  for (genvar m = 0; m < MASTERS; m++) begin : g_starve
    logic [c_CNTW-1:0] r_wait;

    // Count cycles spent requesting without the grant, saturating at the limit
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_wait <= '0;
      end else if (w_req[m] && (r_gidx != IDXW'(m))) begin
        if (r_wait != c_LIMIT) r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end

    assign w_eff[m] = (r_wait == c_LIMIT) ? {PRIO_BITS{1'b1}} : mstpriority[m];
  end
`else
  assign w_eff = mstpriority;
`endif

  // Highest effective priority among requesters, then its candidate set
  always_comb begin
    w_level = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (w_req[m] && (w_eff[m] > w_level)) w_level = w_eff[m];
    end
    for (int m = 0; m < MASTERS; m++) begin
      w_cand[m] = w_req[m] & (w_eff[m] == w_level);
    end
  end

  peripheral_msi_arb_rr_ahb3 #(
    .MASTERS (MASTERS),
    .IDXW    (IDXW)
  ) u_rr (
    .cand       (w_cand),
    .last_idx   (r_last[w_level]),
    .next_idx   (w_rr_next),
    .next_valid (w_rr_valid)
  );

  // Lock / burst hold freeze the grant on the current address-phase owner
  always_comb begin
    arb_locked = mstHMASTLOCK[r_gidx] |
                 ((BURST_HOLD != 0) && (mstHTRANS[r_gidx] == c_HTRANS_SEQ));
    w_legal     = slv_HREADY & ~slv_HRESP & ~arb_locked &
                  (can_switch[r_gidx] | ~w_req[r_gidx]);
    w_arb_point = w_legal & w_rr_valid;
    w_switch    = w_arb_point & (w_rr_next != r_gidx);
  end

  // Grant, round-robin history and first-beat flag. The level pointer moves
  // at every arbitration point even when the winner is the current owner;
  // otherwise an owner re-selected from a stale pointer would never yield.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_gidx       <= '0;
      r_granted    <= c_ONE;
      r_last       <= {NLVL{c_LAST_RST}};
      r_first_beat <= 1'b0;
    end else begin
      if (w_arb_point) r_last[w_level] <= w_rr_next;
      if (w_switch) begin
        r_gidx    <= w_rr_next;
        r_granted <= c_ONE << w_rr_next;
      end
      if (w_switch)        r_first_beat <= 1'b1;
      else if (slv_HREADY) r_first_beat <= 1'b0;
    end
  end

  // Data-phase owner follows the address phase each time the slave is ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_downer <= '0;
      r_dvalid <= 1'b0;
    end else if (slv_HREADY) begin
      r_downer <= r_gidx;
      r_dvalid <= slv_HSEL & slv_HTRANS[1];
    end
  end

  // Address-phase mux to the slave, with SEQ demoted on a fresh grant
  always_comb begin
    slv_HSEL      = mstHSEL[r_gidx];
    slv_HADDR     = mstHADDR[r_gidx];
    slv_HWRITE    = mstHWRITE[r_gidx];
    slv_HSIZE     = mstHSIZE[r_gidx];
    slv_HBURST    = mstHBURST[r_gidx];
    slv_HPROT     = mstHPROT[r_gidx];
    slv_HMASTLOCK = mstHMASTLOCK[r_gidx];
    slv_HREADYOUT = mstHREADY[r_gidx];
    slv_HWDATA    = mstHWDATA[r_downer];
    slv_HTRANS    = mstHTRANS[r_gidx];
    if (r_first_beat && (mstHTRANS[r_gidx] == c_HTRANS_SEQ)) begin
      slv_HTRANS = c_HTRANS_NONSEQ;
    end
  end

  // Per-master responses: owner sees the slave, losers are stalled
  always_comb begin
    mstHRDATA      = slv_HRDATA;
    granted_master = r_granted;
    for (int m = 0; m < MASTERS; m++) begin
      mstHREADYOUT[m] = ((r_dvalid && (r_downer == IDXW'(m))) ? slv_HREADY : 1'b1) &
                        ~(w_req[m] & (r_gidx != IDXW'(m)));
      mstHRESP[m]     = r_dvalid & (r_downer == IDXW'(m)) & slv_HRESP;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_slave_port_arb_ahb3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_msi_slave_port_arb_ahb3
//  Brief    : Directed self-checking bench for the AHB3 slave-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_slave_port_arb_ahb3;
  import peripheral_msi_ahb3_pkg::*;

  localparam int PLEN = 64;
  localparam int XLEN = 64;
  localparam int MASTERS = 5;
  localparam int PRIO_BITS = 3;
  localparam int STARVE_LIMIT = 15;

  logic                              HCLK;
  logic                              HRESETn;
  logic [MASTERS-1:0][PRIO_BITS-1:0] mstpriority;
  logic [MASTERS-1:0]                mstHSEL;
  logic [MASTERS-1:0][PLEN-1:0]      mstHADDR;
  logic [MASTERS-1:0][XLEN-1:0]      mstHWDATA;
  logic [MASTERS-1:0]                mstHWRITE;
  logic [MASTERS-1:0][2:0]           mstHSIZE;
  logic [MASTERS-1:0][2:0]           mstHBURST;
  logic [MASTERS-1:0][3:0]           mstHPROT;
  logic [MASTERS-1:0][1:0]           mstHTRANS;
  logic [MASTERS-1:0]                mstHMASTLOCK;
  logic [MASTERS-1:0]                mstHREADY;
  logic [XLEN-1:0]                   mstHRDATA;
  logic [MASTERS-1:0]                mstHREADYOUT;
  logic [MASTERS-1:0]                mstHRESP;
  logic                              slv_HSEL;
  logic [PLEN-1:0]                   slv_HADDR;
  logic [XLEN-1:0]                   slv_HWDATA;
  logic                              slv_HWRITE;
  logic [2:0]                        slv_HSIZE;
  logic [2:0]                        slv_HBURST;
  logic [3:0]                        slv_HPROT;
  logic [1:0]                        slv_HTRANS;
  logic                              slv_HMASTLOCK;
  logic                              slv_HREADYOUT;
  logic [XLEN-1:0]                   slv_HRDATA;
  logic                              slv_HREADY;
  logic                              slv_HRESP;
  logic [MASTERS-1:0]                can_switch;
  logic [MASTERS-1:0]                granted_master;
  logic                              arb_locked;

  int n_checks = 0;
  int n_errors = 0;

  peripheral_msi_slave_port_arb_ahb3 #(
    .PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS), .PRIO_BITS(PRIO_BITS),
    .BURST_HOLD(1), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mstpriority(mstpriority),
    .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA),
    .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST),
    .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK),
    .mstHREADY(mstHREADY), .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT),
    .mstHRESP(mstHRESP), .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR),
    .slv_HWDATA(slv_HWDATA), .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE),
    .slv_HBURST(slv_HBURST), .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS),
    .slv_HMASTLOCK(slv_HMASTLOCK), .slv_HREADYOUT(slv_HREADYOUT),
    .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY), .slv_HRESP(slv_HRESP),
    .can_switch(can_switch), .granted_master(granted_master), .arb_locked(arb_locked)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic clear_inputs();
    mstpriority  = '0;
    mstHSEL      = '0;
    mstHADDR     = '0;
    mstHWDATA    = '0;
    mstHWRITE    = '0;
    mstHSIZE     = '0;
    mstHBURST    = '0;
    mstHPROT     = '0;
    mstHTRANS    = '0;
    mstHMASTLOCK = '0;
    mstHREADY    = '1;
    can_switch   = '1;
    slv_HRDATA   = 64'hDEAD_BEEF_CAFE_F00D;
    slv_HREADY   = 1'b1;
    slv_HRESP    = 1'b0;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    clear_inputs();
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    clear_inputs();
    mstHSEL[2] = 1'b1; mstHTRANS[2] = c_HTRANS_NONSEQ;
    mstHMASTLOCK[0] = 1'b1;
    tick();
    n_checks++; if (granted_master !== 5'b00001) begin n_errors++; $display("FAIL reset_grant: got %b expected %b", granted_master, 5'b00001); end
    n_checks++; if (mstHREADYOUT !== 5'b11011) begin n_errors++; $display("FAIL reset_hreadyout: got %b expected %b", mstHREADYOUT, 5'b11011); end
    n_checks++; if (mstHRESP !== 5'b00000) begin n_errors++; $display("FAIL reset_hresp: got %b expected %b", mstHRESP, 5'b00000); end
    n_checks++; if (arb_locked !== 1'b1) begin n_errors++; $display("FAIL reset_locked: got %b expected %b", arb_locked, 1'b1); end
    clear_inputs();
    #1;
    n_checks++; if (arb_locked !== 1'b0) begin n_errors++; $display("FAIL reset_unlocked: got %b expected %b", arb_locked, 1'b0); end
  endtask

  task automatic test_single_master();
    do_reset();
    mstHSEL[0] = 1'b1; mstHTRANS[0] = c_HTRANS_NONSEQ; mstHADDR[0] = 64'h100;
    tick();
    n_checks++; if (granted_master !== 5'b00001) begin n_errors++; $display("FAIL single_grant: got %b expected %b", granted_master, 5'b00001); end
    n_checks++; if (slv_HADDR !== 64'h100) begin n_errors++; $display("FAIL single_haddr: got %h expected %h", slv_HADDR, 64'h100); end
    n_checks++; if (slv_HTRANS !== c_HTRANS_NONSEQ) begin n_errors++; $display("FAIL single_htrans: got %b expected %b", slv_HTRANS, c_HTRANS_NONSEQ); end
    n_checks++; if (mstHREADYOUT !== 5'b11111) begin n_errors++; $display("FAIL single_hreadyout: got %b expected %b", mstHREADYOUT, 5'b11111); end
    n_checks++; if (mstHRDATA !== 64'hDEAD_BEEF_CAFE_F00D) begin n_errors++; $display("FAIL single_hrdata: got %h expected %h", mstHRDATA, 64'hDEAD_BEEF_CAFE_F00D); end
    mstHSEL[0] = 1'b0; mstHTRANS[0] = c_HTRANS_IDLE;
    slv_HREADY = 1'b0;
    #1;
    n_checks++; if (mstHREADYOUT !== 5'b11110) begin n_errors++; $display("FAIL single_dphase_wait: got %b expected %b", mstHREADYOUT, 5'b11110); end
    slv_HREADY = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g  [4];
    logic [4:0] exp_ro [4];
    exp_g  = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
    exp_ro = '{5'b10111, 5'b11101, 5'b10111, 5'b11101};
    do_reset();
    mstpriority[1] = 3'd2; mstHSEL[1] = 1'b1; mstHTRANS[1] = c_HTRANS_NONSEQ;
    mstpriority[3] = 3'd2; mstHSEL[3] = 1'b1; mstHTRANS[3] = c_HTRANS_NONSEQ;
    #1;
    n_checks++; if (mstHREADYOUT !== 5'b10101) begin n_errors++; $display("FAIL rr_pre_wait: got %b expected %b", mstHREADYOUT, 5'b10101); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (granted_master !== exp_g[k]) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, granted_master, exp_g[k]); end
      n_checks++; if (mstHREADYOUT !== exp_ro[k]) begin n_errors++; $display("FAIL rr_hreadyout[%0d]: got %b expected %b", k, mstHREADYOUT, exp_ro[k]); end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    mstpriority[1] = 3'd2; mstHSEL[1] = 1'b1; mstHTRANS[1] = c_HTRANS_NONSEQ;
    mstHADDR[1] = 64'h1000; mstHWDATA[1] = 64'hAAAA_5555_0000_1111;
    tick();
    n_checks++; if (granted_master !== 5'b00010) begin n_errors++; $display("FAIL preempt_first: got %b expected %b", granted_master, 5'b00010); end
    mstpriority[2] = 3'd5; mstHSEL[2] = 1'b1; mstHTRANS[2] = c_HTRANS_NONSEQ;
    mstHADDR[2] = 64'h2000; mstHWDATA[2] = 64'h2222_3333_4444_5555;
    slv_HREADY = 1'b0;
    #1;
    n_checks++; if (mstHREADYOUT !== 5'b11011) begin n_errors++; $display("FAIL preempt_wait: got %b expected %b", mstHREADYOUT, 5'b11011); end
    tick();
    n_checks++; if (granted_master !== 5'b00010) begin n_errors++; $display("FAIL preempt_stall: got %b expected %b", granted_master, 5'b00010); end
    slv_HREADY = 1'b1;
    tick();
    n_checks++; if (granted_master !== 5'b00100) begin n_errors++; $display("FAIL preempt_grant: got %b expected %b", granted_master, 5'b00100); end
    n_checks++; if (slv_HWDATA !== 64'hAAAA_5555_0000_1111) begin n_errors++; $display("FAIL preempt_hwdata: got %h expected %h", slv_HWDATA, 64'hAAAA_5555_0000_1111); end
    n_checks++; if (slv_HADDR !== 64'h2000) begin n_errors++; $display("FAIL preempt_haddr: got %h expected %h", slv_HADDR, 64'h2000); end
  endtask

  task automatic test_lock();
    do_reset();
    mstHSEL[0] = 1'b1; mstHTRANS[0] = c_HTRANS_NONSEQ; mstHMASTLOCK[0] = 1'b1;
    mstpriority[4] = 3'd3; mstHSEL[4] = 1'b1; mstHTRANS[4] = c_HTRANS_NONSEQ;
    #1;
    n_checks++; if (arb_locked !== 1'b1) begin n_errors++; $display("FAIL lock_flag: got %b expected %b", arb_locked, 1'b1); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if ({granted_master, arb_locked} !== {5'b00001, 1'b1}) begin n_errors++; $display("FAIL lock_hold[%0d]: got %b/%b expected 00001/1", k, granted_master, arb_locked); end
    end
    mstHMASTLOCK[0] = 1'b0; mstHSEL[0] = 1'b0; mstHTRANS[0] = c_HTRANS_IDLE;
    #1;
    n_checks++; if (arb_locked !== 1'b0) begin n_errors++; $display("FAIL lock_drop: got %b expected %b", arb_locked, 1'b0); end
    tick();
    n_checks++; if (granted_master !== 5'b10000) begin n_errors++; $display("FAIL lock_release_grant: got %b expected %b", granted_master, 5'b10000); end
  endtask

  task automatic test_seq_fixup_error();
    do_reset();
    mstpriority[1] = 3'd1; mstHSEL[1] = 1'b1; mstHTRANS[1] = c_HTRANS_SEQ; mstHADDR[1] = 64'h204;
    tick();
    n_checks++; if (granted_master !== 5'b00010) begin n_errors++; $display("FAIL fixup_grant: got %b expected %b", granted_master, 5'b00010); end
    n_checks++; if (slv_HTRANS !== c_HTRANS_NONSEQ) begin n_errors++; $display("FAIL fixup_nonseq: got %b expected %b", slv_HTRANS, c_HTRANS_NONSEQ); end
    n_checks++; if (arb_locked !== 1'b1) begin n_errors++; $display("FAIL fixup_burst_hold: got %b expected %b", arb_locked, 1'b1); end
    tick();
    n_checks++; if (slv_HTRANS !== c_HTRANS_SEQ) begin n_errors++; $display("FAIL fixup_seq: got %b expected %b", slv_HTRANS, c_HTRANS_SEQ); end
    slv_HRESP = 1'b1; slv_HREADY = 1'b0;
    #1;
    n_checks++; if (mstHRESP !== 5'b00010) begin n_errors++; $display("FAIL err1_hresp: got %b expected %b", mstHRESP, 5'b00010); end
    n_checks++; if (mstHREADYOUT !== 5'b11101) begin n_errors++; $display("FAIL err1_hreadyout: got %b expected %b", mstHREADYOUT, 5'b11101); end
    tick();
    slv_HREADY = 1'b1;
    mstHTRANS[1] = c_HTRANS_IDLE;
    mstpriority[3] = 3'd7; mstHSEL[3] = 1'b1; mstHTRANS[3] = c_HTRANS_NONSEQ;
    #1;
    n_checks++; if (mstHRESP !== 5'b00010) begin n_errors++; $display("FAIL err2_hresp: got %b expected %b", mstHRESP, 5'b00010); end
    tick();
    n_checks++; if (granted_master !== 5'b00010) begin n_errors++; $display("FAIL err_no_switch: got %b expected %b", granted_master, 5'b00010); end
    slv_HRESP = 1'b0;
    #1;
    n_checks++; if (mstHRESP !== 5'b00000) begin n_errors++; $display("FAIL err_cleared: got %b expected %b", mstHRESP, 5'b00000); end
    tick();
    n_checks++; if (granted_master !== 5'b01000) begin n_errors++; $display("FAIL err_after_switch: got %b expected %b", granted_master, 5'b01000); end
  endtask

  task automatic test_starvation();
    int first;
    first = 0;
    do_reset();
    mstpriority[0] = 3'd7; mstHSEL[0] = 1'b1; mstHTRANS[0] = c_HTRANS_NONSEQ;
    mstpriority[1] = 3'd7; mstHSEL[1] = 1'b1; mstHTRANS[1] = c_HTRANS_NONSEQ;
    mstpriority[4] = 3'd0; mstHSEL[4] = 1'b1; mstHTRANS[4] = c_HTRANS_NONSEQ;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (granted_master[4] && (first == 0)) first = k;
    end
`ifdef MSI_ARB_STARVE_EN
    n_checks++; if ((first == 0) || (first > STARVE_LIMIT + 2)) begin n_errors++; $display("FAIL starve_grant_cycle: got %0d expected 1..%0d", first, STARVE_LIMIT + 2); end
`else
    n_checks++; if (first != 0) begin n_errors++; $display("FAIL starve_no_aging: got %0d expected 0", first); end
`endif
  endtask

  initial begin
    HRESETn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_master();
    test_round_robin();
    test_preempt();
    test_lock();
    test_seq_fixup_error();
    test_starvation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
